// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column sweep, sweep-level debounce, valid/ack key report.
// Optional build macro KEYPAD_REPEAT_EN re-reports a held key every REPEAT_SCANS sweeps.
module keypad_scanner #(
    parameter logic [31:0] SCAN_TICKS     = 32'd50_000,
    parameter logic [7:0]  DEBOUNCE_SCANS = 8'd4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_overrun
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_DEB_PRESS = 2'd1;
    localparam logic [1:0] ST_PRESSED   = 2'd2;
    localparam logic [1:0] ST_DEB_REL   = 2'd3;
`ifdef KEYPAD_REPEAT_EN
    localparam logic [7:0] REPEAT_SCANS = 8'd32;
`endif

    logic [3:0]  rows_p0;
    logic [3:0]  rows_p1;
    logic [3:0]  pressed;
    logic [31:0] tick;
    logic [1:0]  col_idx;
    logic [15:0] snapshot;
    logic [15:0] sweep_snap;
    logic        col_done;
    logic        sweep_end;
    logic [4:0]  pick;
    logic        cand_vld;
    logic [3:0]  cand;
    logic        same;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nxt;
    logic [3:0]  cand_reg;
    logic [3:0]  cand_nxt;
    logic        report;
    logic [3:0]  report_code;
    logic        ack_eff;
`ifdef KEYPAD_REPEAT_EN
    logic [7:0]  rpt_cnt;
    logic [7:0]  rpt_nxt;
`endif

    // Returns {exactly_one_set, index_of_set_bit}; ghosted or empty sweeps give valid=0.
    function automatic logic [4:0] pick_single(input logic [15:0] s);
        logic [4:0] r;
        int         n;
        r = '0;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (s[i]) begin
                n++;
                r[3:0] = 4'(i);
            end
        end
        r[4] = (n == 1);
        return r;
    endfunction

    // stage p0/p1: two-flop synchronizer for the asynchronous row inputs
    always_ff @(posedge clock) begin
        rows_p0 <= rows;
        rows_p1 <= rows_p0;
    end

    assign pressed    = ~rows_p1;
    assign col_done   = (tick == SCAN_TICKS - 32'd1);
    assign sweep_end  = col_done && (col_idx == 2'd3);
    assign sweep_snap = {pressed, snapshot[11:0]};
    assign pick       = pick_single(sweep_snap);
    assign cand_vld   = pick[4];
    assign cand       = pick[3:0];
    assign same       = cand_vld && (cand == cand_reg);
    assign ack_eff    = key_ack && key_valid;

    // stage scan: column dwell counter and per-column row capture
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            tick     <= '0;
            col_idx  <= 2'd0;
            cols     <= 4'b1110;
            snapshot <= '0;
        end else if (col_done) begin
            tick                        <= '0;
            col_idx                     <= col_idx + 2'd1;
            cols                        <= ~(4'b0001 << (col_idx + 2'd1));
            snapshot[{col_idx, 2'b00} +: 4] <= pressed;
        end else begin
            tick <= tick + 32'd1;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        cand_nxt    = cand_reg;
        report      = 1'b0;
        report_code = cand_reg;
`ifdef KEYPAD_REPEAT_EN
        rpt_nxt     = rpt_cnt;
`endif
        if (sweep_end) begin
            case (state)
                ST_IDLE: begin
                    if (cand_vld) begin
                        cand_nxt    = cand;
                        report_code = cand;
                        cnt_nxt     = 8'd1;
                        if (DEBOUNCE_SCANS <= 8'd1) begin
                            report    = 1'b1;
                            state_nxt = ST_PRESSED;
                            cnt_nxt   = 8'd0;
`ifdef KEYPAD_REPEAT_EN
                            rpt_nxt   = 8'd0;
`endif
                        end else begin
                            state_nxt = ST_DEB_PRESS;
                        end
                    end
                end
                ST_DEB_PRESS: begin
                    if (same) begin
                        cnt_nxt = cnt + 8'd1;
                        if (cnt_nxt >= DEBOUNCE_SCANS) begin
                            report    = 1'b1;
                            state_nxt = ST_PRESSED;
                            cnt_nxt   = 8'd0;
`ifdef KEYPAD_REPEAT_EN
                            rpt_nxt   = 8'd0;
`endif
                        end
                    end else begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = 8'd0;
                    end
                end
                ST_PRESSED: begin
                    if (!same) begin
                        if (DEBOUNCE_SCANS <= 8'd1) begin
                            state_nxt = ST_IDLE;
                            cnt_nxt   = 8'd0;
                        end else begin
                            state_nxt = ST_DEB_REL;
                            cnt_nxt   = 8'd1;
                        end
                    end else begin
`ifdef KEYPAD_REPEAT_EN
                        rpt_nxt = rpt_cnt + 8'd1;
                        if (rpt_nxt >= REPEAT_SCANS) begin
                            report  = 1'b1;
                            rpt_nxt = 8'd0;
                        end
`endif
                    end
                end
                default: begin
                    if (!same) begin
                        cnt_nxt = cnt + 8'd1;
                        if (cnt_nxt >= DEBOUNCE_SCANS) begin
                            state_nxt = ST_IDLE;
                            cnt_nxt   = 8'd0;
                        end
                    end else begin
                        // Bounce during release: back to held without a second report.
                        state_nxt = ST_PRESSED;
                        cnt_nxt   = 8'd0;
`ifdef KEYPAD_REPEAT_EN
                        rpt_nxt   = 8'd0;
`endif
                    end
                end
            endcase
        end
    end

    // stage fsm: debounce state and candidate register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            cnt     <= 8'd0;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt <= 8'd0;
`endif
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt <= rpt_nxt;
`endif
        end
    end

    always_ff @(posedge clock) begin
        cand_reg <= cand_nxt;
    end

    // stage out: report/handshake; an ack in the same cycle frees the slot for the new code
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            key_code    <= 4'd0;
            key_valid   <= 1'b0;
            key_overrun <= 1'b0;
        end else if (report) begin
            if (!key_valid || ack_eff) begin
                key_code    <= report_code;
                key_valid   <= 1'b1;
                key_overrun <= 1'b0;
            end else begin
                key_overrun <= 1'b1;
            end
        end else if (ack_eff) begin
            key_valid   <= 1'b0;
            key_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, sweep-level reference model,
// directed vector table, reset-in-debounce sequence and randomized key sessions.
module tb_keypad_scanner;

    localparam logic [31:0] ST = 32'd4;
    localparam logic [7:0]  DB = 8'd2;
    localparam int SWEEP = 16;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       key_ack;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_overrun;
    logic [15:0] keys;

    int vectors = 0;
    int miscompares = 0;

    int         k;
    int         held;
    int         pend;
    int         agree;
    int         rel;
    int         rpt;
    bit         mvalid;
    bit         movr;
    logic [3:0] mcode;
    logic [3:0] mcols;

    typedef struct {
        logic [15:0] keys;
        int          nsw;
        bit          ack;
        bit          ev;
        logic [3:0]  ec;
        bit          eo;
    } vec_t;
    vec_t tbl[17];

    keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DB)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .rows(rows),
        .cols(cols),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_ack(key_ack),
        .key_overrun(key_overrun)
    );

    always #5 clock = ~clock;

    // Passive matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        rows = 4'hF;
        for (int c = 0; c < 4; c++)
            if (cols[c] == 1'b0)
                for (int r = 0; r < 4; r++)
                    if (keys[c*4+r]) rows[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
        end
    endtask

    function automatic int cand_of(input logic [15:0] m);
        if ($countones(m) == 1) return $clog2(m);
        return -1;
    endfunction

    task automatic model_step();
        bit         ack;
        bit         rep;
        int         c;
        logic [3:0] rc;
        if (!reset_n) begin
            k = 0; held = -1; pend = -1; agree = 0; rel = 0; rpt = 0;
            mvalid = 1'b0; movr = 1'b0; mcode = 4'd0;
        end else begin
            k++;
            ack = key_ack && mvalid;
            rep = 1'b0;
            rc  = 4'd0;
            if (k % SWEEP == 0) begin
                c = cand_of(keys);
                if (held < 0) begin
                    if (pend < 0) begin
                        if (c >= 0) begin pend = c; agree = 1; end
                    end else if (c == pend) agree++;
                    else begin pend = -1; agree = 0; end
                    if (pend >= 0 && agree >= int'(DB)) begin
                        held = pend; pend = -1; agree = 0; rel = 0; rpt = 0;
                        rep = 1'b1; rc = 4'(held);
                    end
                end else if (c == held) begin
                    if (rel > 0) begin
                        rel = 0; rpt = 0;
                    end else begin
`ifdef KEYPAD_REPEAT_EN
                        rpt++;
                        if (rpt == 32) begin rpt = 0; rep = 1'b1; rc = 4'(held); end
`endif
                    end
                end else begin
                    rel++;
                    if (rel >= int'(DB)) begin held = -1; rel = 0; end
                end
            end
            if (rep) begin
                if (!mvalid || ack) begin mcode = rc; mvalid = 1'b1; movr = 1'b0; end
                else movr = 1'b1;
            end else if (ack) begin
                mvalid = 1'b0; movr = 1'b0;
            end
        end
        mcols = ~(4'b0001 << ((k / 4) % 4));
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check("cols", 32'(cols), 32'(mcols));
        check("key_valid", 32'(key_valid), 32'(mvalid));
        check("key_overrun", 32'(key_overrun), 32'(movr));
        if (mvalid) check("key_code", 32'(key_code), 32'(mcode));
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        tbl[0]  = '{16'h0200, 1, 1'b0, 1'b0, 4'd0,  1'b0};
        tbl[1]  = '{16'h0200, 1, 1'b0, 1'b1, 4'd9,  1'b0};
        tbl[2]  = '{16'h0200, 1, 1'b1, 1'b0, 4'd9,  1'b0};
        tbl[3]  = '{16'h0000, 2, 1'b0, 1'b0, 4'd9,  1'b0};
        tbl[4]  = '{16'h0021, 3, 1'b0, 1'b0, 4'd9,  1'b0};
        tbl[5]  = '{16'h0001, 2, 1'b0, 1'b1, 4'd0,  1'b0};
        tbl[6]  = '{16'h0001, 1, 1'b1, 1'b0, 4'd0,  1'b0};
        tbl[7]  = '{16'h0000, 2, 1'b0, 1'b0, 4'd0,  1'b0};
        tbl[8]  = '{16'h0008, 2, 1'b0, 1'b1, 4'd3,  1'b0};
        tbl[9]  = '{16'h0000, 2, 1'b0, 1'b1, 4'd3,  1'b0};
        tbl[10] = '{16'h1000, 2, 1'b0, 1'b1, 4'd3,  1'b1};
        tbl[11] = '{16'h1000, 1, 1'b1, 1'b0, 4'd3,  1'b0};
        tbl[12] = '{16'h0000, 2, 1'b0, 1'b0, 4'd3,  1'b0};
        tbl[13] = '{16'h0080, 1, 1'b0, 1'b0, 4'd3,  1'b0};
        tbl[14] = '{16'h0000, 1, 1'b0, 1'b0, 4'd3,  1'b0};
        tbl[15] = '{16'h0080, 1, 1'b0, 1'b0, 4'd3,  1'b0};
        tbl[16] = '{16'h0000, 1, 1'b0, 1'b0, 4'd3,  1'b0};

        reset_n = 1'b0;
        key_ack = 1'b0;
        keys    = 16'h0000;
        run_cycles(3);
        check("rst_cols", 32'(cols), 32'h0000_000E);
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_overrun", 32'(key_overrun), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            keys = tbl[i].keys;
            key_ack = tbl[i].ack;
            cycle();
            key_ack = 1'b0;
            run_cycles(tbl[i].nsw * SWEEP - 1);
            check($sformatf("tbl%0d_valid", i), 32'(key_valid), 32'(tbl[i].ev));
            check($sformatf("tbl%0d_code", i), 32'(key_code), 32'(tbl[i].ec));
            check($sformatf("tbl%0d_overrun", i), 32'(key_overrun), 32'(tbl[i].eo));
        end

        // Reset while debouncing a press must drop it entirely.
        keys = 16'h0080;
        run_cycles(SWEEP + 5);
        reset_n = 1'b0;
        run_cycles(2);
        check("rst2_code", 32'(key_code), 32'd0);
        check("rst2_valid", 32'(key_valid), 32'd0);
        reset_n = 1'b1;
        run_cycles(SWEEP);
        check("rst2_no_report", 32'(key_valid), 32'd0);
        run_cycles(SWEEP);
        check("rst2_late_valid", 32'(key_valid), 32'd1);
        check("rst2_late_code", 32'(key_code), 32'd7);
        key_ack = 1'b1;
        cycle();
        key_ack = 1'b0;
        check("rst2_ack", 32'(key_valid), 32'd0);
        run_cycles(SWEEP - 1);
        keys = 16'h0000;
        run_cycles(2 * SWEEP);

        for (int seg = 0; seg < 120; seg++) begin
            int sel;
            int nsw;
            sel = int'($urandom_range(0, 19));
            if (sel < 8) keys = 16'h0000;
            else if (sel < 17) keys = 16'h0001 << $urandom_range(0, 15);
            else keys = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            nsw = int'($urandom_range(1, 4));
            for (int i = 0; i < nsw * SWEEP; i++) begin
                key_ack = ($urandom_range(0, 7) == 0);
                cycle();
            end
        end
        key_ack = 1'b0;

`ifdef KEYPAD_REPEAT_EN
        begin
            int  nrep;
            bit  prev;
            keys = 16'h0000;
            key_ack = 1'b1;
            run_cycles(3 * SWEEP);
            keys = 16'h0010;
            nrep = 0;
            prev = key_valid;
            for (int i = 0; i < 70 * SWEEP; i++) begin
                cycle();
                if (key_valid && !prev) nrep++;
                prev = key_valid;
            end
            check("repeat_count", 32'(nrep), 32'd3);
            key_ack = 1'b0;
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
